sl3p_link_ctrl: RTL and testbench

- Link bring-up and retrain sequencer for the SL3 66-bit ECC 2-lane SERDES.
- Lives in the clk100 (mgmt clock) domain.
- Drives the SERDES wrapper's async reset input.
- Watches PLL lock, word lock, deskew lock and per-lane uncorrected-ECC events, and declares link up.
- Forces a full reset/retrain on lock loss, lock timeout, excessive uncorrected errors, or software request.

---
 rtl/sl3p_link_pkg.sv | 21 ++
 rtl/sl3p_link_sync.sv | 38 +++
 rtl/sl3p_link_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sl3p_link_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sl3p_link_pkg.sv
// Shared types and helpers for the SL3 link bring-up/retrain sequencer.
package sl3p_link_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    UP        = 3'd4
  } state_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/sl3p_link_sync.sv
// 2-flop synchronizer; with EDGE_EN the output is a one-cycle pulse per synced edge
// (third flop for edge detect) instead of the synced level.
module sl3p_link_sync #(
  parameter int WIDTH   = 1,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] s3_q;
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) s3_q <= '0;
        else          s3_q <= s2_q;
      end
      assign out_o = s2_q ^ s3_q;
    end else begin : g_level
      assign out_o = s2_q;
    end
  endgenerate

endmodule

// File: rtl/sl3p_link_ctrl.sv
// SL3 2-lane SERDES link bring-up / retrain sequencer (clk100 domain).
// Define SL3P_LINK_CTRL_STATS_EN to build the retrain and uncorrected-event counters.
module sl3p_link_ctrl
  import sl3p_link_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int HOLD_CYCLES   = 64,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int FAIL_WINDOW   = 4096,
  parameter int FAIL_THRESH   = 8
) (
  input  logic              clk100,
  input  logic              rst100_n,
  input  logic              enable,
  input  logic              force_retrain,
  input  logic [LANES-1:0]  tx_pll_locked_a,
  input  logic [LANES-1:0]  word_lock_a,
  input  logic              deskew_locked_a,
  input  logic [LANES-1:0]  rx_fail_tgl,
  output logic              link_rst,
  output logic              link_up,
  output logic [2:0]        state,
  output logic              retrain_pulse,
  output logic [STAT_W-1:0] retrain_cnt,
  output logic [STAT_W-1:0] fail_cnt
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > HOLD_CYCLES) ?
                           ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES) :
                           ((HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int WIN_W = (FAIL_WINDOW > 1) ? $clog2(FAIL_WINDOW) : 1;
  localparam int ACC_W = $clog2(FAIL_THRESH + LANES + 1);
  localparam int EVT_W = $clog2(LANES + 1);

  logic [2*LANES:0] lock_s;
  logic [LANES-1:0] evt;
  logic             all_lock;
  logic [EVT_W-1:0] evt_sum;

  sl3p_link_sync #(.WIDTH(2*LANES+1), .EDGE_EN(1'b0)) u_lock_sync (
    .clk_i(clk100), .rst_n_i(rst100_n),
    .d_i({deskew_locked_a, word_lock_a, tx_pll_locked_a}), .out_o(lock_s)
  );

  sl3p_link_sync #(.WIDTH(LANES), .EDGE_EN(1'b1)) u_fail_sync (
    .clk_i(clk100), .rst_n_i(rst100_n), .d_i(rx_fail_tgl), .out_o(evt)
  );

  assign all_lock = &lock_s;

  always_comb begin
    evt_sum = '0;
    for (int i = 0; i < LANES; i++) evt_sum = evt_sum + EVT_W'(evt[i]);
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d, win_nxt;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
  logic             link_rst_q, link_up_q, pulse_q, retrain;

  // The window accumulator restarts from this cycle's events at wrap, so nothing is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = '0;
    acc_d   = '0;
    if (win_q == WIN_W'(FAIL_WINDOW-1)) begin
      win_nxt = '0;
      acc_nxt = ACC_W'(evt_sum);
    end else begin
      win_nxt = win_q + WIN_W'(1);
      acc_nxt = acc_q + ACC_W'(evt_sum);
    end
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (force_retrain && (state_q inside {HOLD, WAIT_LOCK, STABLE, UP})) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES-1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (all_lock) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT-1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        STABLE: begin
          if (!all_lock) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES-1)) begin
            state_d = UP;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        UP: begin
          if (!all_lock || (acc_nxt >= ACC_W'(FAIL_THRESH))) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            win_d = win_nxt;
            acc_d = acc_nxt;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign retrain = (state_d == HOLD) && (state_q inside {WAIT_LOCK, STABLE, UP});

  always_ff @(posedge clk100) begin
    if (!rst100_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      link_rst_q <= 1'b1;
      link_up_q  <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      link_rst_q <= !(state_d inside {WAIT_LOCK, STABLE, UP});
      link_up_q  <= (state_d == UP);
      pulse_q    <= retrain;
    end
  end

  assign state         = state_q;
  assign link_rst      = link_rst_q;
  assign link_up       = link_up_q;
  assign retrain_pulse = pulse_q;

`ifdef SL3P_LINK_CTRL_STATS_EN
  logic [STAT_W-1:0] retrain_cnt_q, fail_cnt_q;

  always_ff @(posedge clk100) begin
    if (!rst100_n) begin
      retrain_cnt_q <= '0;
      fail_cnt_q    <= '0;
    end else begin
      if (retrain) retrain_cnt_q <= sat_add(retrain_cnt_q, STAT_W'(1));
      fail_cnt_q <= sat_add(fail_cnt_q, STAT_W'(evt_sum));
    end
  end

  assign retrain_cnt = retrain_cnt_q;
  assign fail_cnt    = fail_cnt_q;
`else
  assign retrain_cnt = '0;
  assign fail_cnt    = '0;
`endif

endmodule

// File: tb/tb_sl3p_link_ctrl.sv
// Directed bench for sl3p_link_ctrl with small timing parameters; expectations are
// hand-derived cycle counts relative to the edge that samples enable.
module tb_sl3p_link_ctrl;

  localparam int LANES = 2;
`ifdef SL3P_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk100 = 1'b0;
  logic             rst100_n = 1'b0;
  logic             enable = 1'b0;
  logic             force_retrain = 1'b0;
  logic [LANES-1:0] tx_pll_locked_a = '1;
  logic [LANES-1:0] word_lock_a = '1;
  logic             deskew_locked_a = 1'b1;
  logic [LANES-1:0] rx_fail_tgl = '0;
  logic             link_rst, link_up, retrain_pulse;
  logic [2:0]       state;
  logic [15:0]      retrain_cnt, fail_cnt;

  sl3p_link_ctrl #(
    .LANES(LANES), .HOLD_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8),
    .FAIL_WINDOW(16), .FAIL_THRESH(3)
  ) dut (
    .clk100(clk100), .rst100_n(rst100_n), .enable(enable), .force_retrain(force_retrain),
    .tx_pll_locked_a(tx_pll_locked_a), .word_lock_a(word_lock_a),
    .deskew_locked_a(deskew_locked_a), .rx_fail_tgl(rx_fail_tgl),
    .link_rst(link_rst), .link_up(link_up), .state(state), .retrain_pulse(retrain_pulse),
    .retrain_cnt(retrain_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk100 = ~clk100;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic do_reset(input logic dsk);
    rst100_n = 1'b0;
    enable = 1'b0;
    force_retrain = 1'b0;
    rx_fail_tgl = '0;
    tx_pll_locked_a = '1;
    word_lock_a = '1;
    deskew_locked_a = dsk;
    tick(1);
    chk("rst_state", state, 0);
    chk("rst_link_rst", link_rst, 1);
    chk("rst_link_up", link_up, 0);
    chk("rst_pulse", retrain_pulse, 0);
    chk("rst_retrain_cnt", retrain_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst100_n = 1'b1;
  endtask

  // e = first edge with enable=1: HOLD e..e+3, WAIT_LOCK at e+4, STABLE e+5..e+12, UP at e+13
  task automatic bring_up();
    enable = 1'b1;
    tick(4);
    chk("bu_hold", state, 1);
    chk("bu_rst_held", link_rst, 1);
    tick(1);
    chk("bu_wait", state, 2);
    chk("bu_rst_rel", link_rst, 0);
    tick(1);
    chk("bu_stable", state, 3);
    tick(7);
    chk("bu_stable_end", state, 3);
    chk("bu_not_up", link_up, 0);
    tick(1);
    chk("bu_up", state, 4);
    chk("bu_link_up", link_up, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset(1'b1);
    bring_up();
    chk("bu_retrain_cnt", retrain_cnt, 0);
    chk("bu_no_pulse", retrain_pulse, 0);

    // lock timeout with deskew held low
    do_reset(1'b0);
    enable = 1'b1;
    tick(5);
    chk("to_wait", state, 2);
    for (int i = 1; i <= 3; i++) begin
      tick(31);
      chk("to_still_wait", state, 2);
      tick(1);
      chk("to_hold", state, 1);
      chk("to_pulse", retrain_pulse, 1);
      chk("to_retrain_cnt", retrain_cnt, STATS ? i : 0);
      tick(1);
      chk("to_pulse_clr", retrain_pulse, 0);
      tick(3);
      chk("to_rewait", state, 2);
    end

    // one-cycle word_lock[1] drop seen synced while STABLE count is 5
    do_reset(1'b1);
    enable = 1'b1;
    tick(9);
    word_lock_a[1] = 1'b0;
    tick(1);
    word_lock_a[1] = 1'b1;
    tick(1);
    chk("gl_stable", state, 3);
    tick(1);
    chk("gl_wait", state, 2);
    chk("gl_no_pulse", retrain_pulse, 0);
    tick(1);
    chk("gl_restable", state, 3);
    tick(7);
    chk("gl_not_up", link_up, 0);
    tick(1);
    chk("gl_up", state, 4);
    chk("gl_link_up", link_up, 1);
    chk("gl_retrain_cnt", retrain_cnt, 0);

    // three uncorrected events within one window
    do_reset(1'b1);
    bring_up();
    rx_fail_tgl[0] = ~rx_fail_tgl[0];
    tick(2);
    rx_fail_tgl[0] = ~rx_fail_tgl[0];
    tick(2);
    rx_fail_tgl[1] = ~rx_fail_tgl[1];
    tick(2);
    chk("th_up_at_2", state, 4);
    chk("th_fail_2", fail_cnt, STATS ? 2 : 0);
    tick(1);
    chk("th_hold", state, 1);
    chk("th_link_down", link_up, 0);
    chk("th_pulse", retrain_pulse, 1);
    chk("th_fail_3", fail_cnt, STATS ? 3 : 0);
    chk("th_retrain_cnt", retrain_cnt, STATS ? 1 : 0);

    // enable=0 beats force_retrain; then force_retrain alone
    do_reset(1'b1);
    bring_up();
    force_retrain = 1'b1;
    enable = 1'b0;
    tick(1);
    force_retrain = 1'b0;
    chk("sim_idle", state, 0);
    chk("sim_no_pulse", retrain_pulse, 0);
    chk("sim_link_rst", link_rst, 1);
    chk("sim_link_down", link_up, 0);
    chk("sim_retrain_cnt", retrain_cnt, 0);
    bring_up();
    force_retrain = 1'b1;
    tick(1);
    force_retrain = 1'b0;
    chk("fr_hold", state, 1);
    chk("fr_pulse", retrain_pulse, 1);
    chk("fr_link_down", link_up, 0);
    chk("fr_link_rst", link_rst, 1);
    chk("fr_retrain_cnt", retrain_cnt, STATS ? 1 : 0);
    tick(1);
    chk("fr_pulse_clr", retrain_pulse, 0);

    // events split 2/1 across a window wrap (UP entry U; wrap at U+16)
    do_reset(1'b1);
    bring_up();
    tick(9);
    rx_fail_tgl[0] = ~rx_fail_tgl[0];
    tick(2);
    rx_fail_tgl[0] = ~rx_fail_tgl[0];
    tick(3);
    rx_fail_tgl[1] = ~rx_fail_tgl[1];
    tick(3);
    chk("wr_up", state, 4);
    tick(5);
    chk("wr_still_up", state, 4);
    chk("wr_link_up", link_up, 1);
    chk("wr_fail_cnt", fail_cnt, STATS ? 3 : 0);
    chk("wr_retrain_cnt", retrain_cnt, 0);

    // reset while UP
    do_reset(1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
